// File: rtl/line_read_buffer_pkg.sv
// Shared LC-3b types for the single-line read buffer: word/line/offset/tag widths and FSM states.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cache_size;
  typedef logic [2:0]   lc3b_cache_offset;
  typedef logic [11:0]  lc3b_cache_tag;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RESP
  } lrb_state_t;

endpackage

// File: rtl/line_read_buffer_if.sv
// Datapath read port, invalidate strobe and pmem fill handshake of the line read buffer.
interface line_read_buffer_if;
  import lc3b_types::*;

  logic           mem_read;
  lc3b_word       mem_address;
  logic [1:0]     mem_byte_enable;
  lc3b_word       mem_rdata;
  logic           mem_resp;
  logic           inv;
  lc3b_word       inv_address;
  logic           pmem_read;
  lc3b_word       pmem_address;
  lc3b_cache_size pmem_rdata;
  logic           pmem_resp;

  modport slave (
    input  mem_read, mem_address, mem_byte_enable, inv, inv_address, pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, pmem_read, pmem_address
  );

  modport master (
    output mem_read, mem_address, mem_byte_enable, inv, inv_address, pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, pmem_read, pmem_address
  );
endinterface

// File: rtl/line_read_buffer_extract.sv
// Combinational word select from a 128-bit line with byte-lane masking (read-side line merge).
module line_word_extract
  import lc3b_types::*;
(
  input  lc3b_cache_size   line_i,
  input  lc3b_cache_offset offset_i,
  input  logic [1:0]       be_i,
  output lc3b_word         word_o
);

  lc3b_word word;

  assign word = line_i[{offset_i, 4'b0000} +: 16];

  always_comb begin
    case (be_i)
      2'b01:   word_o = {8'h00, word[7:0]};
      2'b10:   word_o = {word[15:8], 8'h00};
      default: word_o = word;
    endcase
  end

endmodule

// File: rtl/line_read_buffer.sv
// Single-line read buffer between the LC-3b read port and pmem.
// Optional saturating hit/miss counters are built when LINE_READ_STATS_EN is defined.
module line_read_buffer
  import lc3b_types::*;
#(
  parameter int unsigned STAT_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  line_read_buffer_if.slave   bus,
  output logic [STAT_W-1:0]   hit_count,
  output logic [STAT_W-1:0]   miss_count
);

  lrb_state_t       state_q, state_d;
  logic             valid_q, valid_d;
  lc3b_cache_tag    tag_q, tag_d;
  lc3b_cache_tag    fill_tag_q, fill_tag_d;
  lc3b_cache_size   line_q, line_d;
  lc3b_cache_offset off_q, off_d;
  logic [1:0]       be_q, be_d;
  logic             fill_inv_q, fill_inv_d;
  lc3b_word         rdata_q, rdata_d;

  logic             inv_tag_match, inv_fill_match, hit, hit_evt, miss_evt;
  lc3b_cache_size   ext_line;
  lc3b_cache_offset ext_off;
  logic [1:0]       ext_be;
  lc3b_word         ext_word;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{bus.mem_address[0], bus.inv_address[3:0]};

  assign inv_tag_match  = bus.inv && (bus.inv_address[15:4] == tag_q);
  assign inv_fill_match = bus.inv && (bus.inv_address[15:4] == fill_tag_q);
  assign hit            = valid_q && (tag_q == bus.mem_address[15:4]) && !inv_tag_match;

  // Hits read the held line with live request fields; fills read the incoming line.
  assign ext_line = (state_q == FILL) ? bus.pmem_rdata : line_q;
  assign ext_off  = (state_q == IDLE) ? bus.mem_address[3:1] : off_q;
  assign ext_be   = (state_q == IDLE) ? bus.mem_byte_enable : be_q;

  line_word_extract u_extract (
    .line_i   (ext_line),
    .offset_i (ext_off),
    .be_i     (ext_be),
    .word_o   (ext_word)
  );

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    fill_tag_d = fill_tag_q;
    line_d     = line_q;
    off_d      = off_q;
    be_d       = be_q;
    fill_inv_d = fill_inv_q;
    rdata_d    = rdata_q;
    hit_evt    = 1'b0;
    miss_evt   = 1'b0;

    if (inv_tag_match) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.mem_read) begin
          off_d = bus.mem_address[3:1];
          be_d  = bus.mem_byte_enable;
          if (hit) begin
            hit_evt = 1'b1;
            rdata_d = ext_word;
            state_d = RESP;
          end else begin
            miss_evt   = 1'b1;
            fill_tag_d = bus.mem_address[15:4];
            fill_inv_d = 1'b0;
            state_d    = FILL;
          end
        end
      end
      FILL: begin
        if (inv_fill_match) fill_inv_d = 1'b1;
        if (bus.pmem_resp) begin
          line_d  = bus.pmem_rdata;
          tag_d   = fill_tag_q;
          // A write to the line while it was in flight leaves it unusable for later hits.
          valid_d = !(fill_inv_q || inv_fill_match);
          rdata_d = ext_word;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      tag_q      <= '0;
      fill_tag_q <= '0;
      line_q     <= '0;
      off_q      <= '0;
      be_q       <= '0;
      fill_inv_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      fill_tag_q <= fill_tag_d;
      line_q     <= line_d;
      off_q      <= off_d;
      be_q       <= be_d;
      fill_inv_q <= fill_inv_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.mem_resp     = (state_q == RESP);
  assign bus.mem_rdata    = rdata_q;
  assign bus.pmem_read    = (state_q == FILL);
  assign bus.pmem_address = {fill_tag_q, 4'b0000};

`ifdef LINE_READ_STATS_EN
  logic [STAT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_evt && !(&hit_cnt_q))   hit_cnt_d  = hit_cnt_q + 1'b1;
    if (miss_evt && !(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  logic unused_evt;
  assign unused_evt = hit_evt ^ miss_evt;
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_line_read_buffer.sv
// Scoreboard bench for line_read_buffer: directed misses, hits, invalidates and reset mid-fill.
module tb_line_read_buffer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] hit_count, miss_count;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];

  line_read_buffer_if bus ();

  line_read_buffer #(.STAT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_resp === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_resp: got resp data 0x%0h, expected no response",
                   bus.mem_rdata);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("rdata", {16'h0, bus.mem_rdata}, {16'h0, e});
        end
      end
    end
  end

  task automatic do_hit(input logic [15:0] addr, input logic [1:0] be, input logic [15:0] exp);
    bus.mem_read = 1'b1;
    bus.mem_address = addr;
    bus.mem_byte_enable = be;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    check("hit_resp_latency", {31'h0, bus.mem_resp}, 32'h1);
    check("hit_no_pmem", {31'h0, bus.pmem_read}, 32'h0);
    bus.mem_read = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_miss(input logic [15:0] addr, input logic [1:0] be, input logic [127:0] line,
                         input logic [15:0] exp, input bit inv_issue, input bit inv_fill,
                         input logic [15:0] inv_addr);
    bus.mem_read = 1'b1;
    bus.mem_address = addr;
    bus.mem_byte_enable = be;
    if (inv_issue) begin
      bus.inv = 1'b1;
      bus.inv_address = inv_addr;
    end
    exp_q.push_back(exp);
    @(posedge clk); #1;
    bus.inv = 1'b0;
    check("miss_pmem_read", {31'h0, bus.pmem_read}, 32'h1);
    check("miss_pmem_addr", {16'h0, bus.pmem_address}, {16'h0, addr[15:4], 4'h0});
    check("miss_no_resp", {31'h0, bus.mem_resp}, 32'h0);
    if (inv_fill) begin
      bus.inv = 1'b1;
      bus.inv_address = inv_addr;
      @(posedge clk); #1;
      bus.inv = 1'b0;
    end
    @(posedge clk); #1;
    bus.pmem_rdata = line;
    bus.pmem_resp = 1'b1;
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
    check("fill_resp_latency", {31'h0, bus.mem_resp}, 32'h1);
    check("fill_pmem_drop", {31'h0, bus.pmem_read}, 32'h0);
    bus.mem_read = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [127:0] l1;
    l1 = {16'hA5C3, 16'h1006, 16'h1005, 16'h1004, 16'hBEEF, 16'h1002, 16'h1001, 16'h1122};
    bus.mem_read = 1'b0;
    bus.mem_address = '0;
    bus.mem_byte_enable = 2'b00;
    bus.inv = 1'b0;
    bus.inv_address = '0;
    bus.pmem_rdata = '0;
    bus.pmem_resp = 1'b0;

    #12;
    check("rst_mem_resp", {31'h0, bus.mem_resp}, 32'h0);
    check("rst_pmem_read", {31'h0, bus.pmem_read}, 32'h0);
    check("rst_pmem_addr", {16'h0, bus.pmem_address}, 32'h0);
    check("rst_rdata", {16'h0, bus.mem_rdata}, 32'h0);
    check("rst_hit_count", {16'h0, hit_count}, 32'h0);
    check("rst_miss_count", {16'h0, miss_count}, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Cold miss, then hits from the filled line.
    do_miss(16'h1236, 2'b11, l1, 16'hBEEF, 1'b0, 1'b0, 16'h0);
    do_hit(16'h1230, 2'b01, 16'h0022);
    do_hit(16'h123E, 2'b10, 16'hA500);
    do_hit(16'h1232, 2'b00, 16'h1001);
`ifdef LINE_READ_STATS_EN
    check("stats_miss", {16'h0, miss_count}, 32'd1);
    check("stats_hit", {16'h0, hit_count}, 32'd3);
`else
    check("stats_miss_off", {16'h0, miss_count}, 32'd0);
    check("stats_hit_off", {16'h0, hit_count}, 32'd0);
`endif

    // Invalidate during FILL: data still returned, line not kept.
    do_miss(16'h4000, 2'b11, {8{16'h4444}}, 16'h4444, 1'b0, 1'b1, 16'h400A);
    do_miss(16'h4000, 2'b11, {8{16'h5555}}, 16'h5555, 1'b0, 1'b0, 16'h0);

    // Hit coinciding with a matching invalidate is a miss.
    do_miss(16'h1234, 2'b11, {8{16'h2222}}, 16'h2222, 1'b0, 1'b0, 16'h0);
    do_miss(16'h1234, 2'b11, {8{16'h3333}}, 16'h3333, 1'b1, 1'b0, 16'h1238);

    // Reset while filling.
    bus.mem_read = 1'b1;
    bus.mem_address = 16'h8000;
    bus.mem_byte_enable = 2'b11;
    @(posedge clk); #1;
    check("rstfill_pmem_read", {31'h0, bus.pmem_read}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstfill_pmem_drop", {31'h0, bus.pmem_read}, 32'h0);
    check("rstfill_no_resp", {31'h0, bus.mem_resp}, 32'h0);
    check("rstfill_hit_count", {16'h0, hit_count}, 32'h0);
    check("rstfill_miss_count", {16'h0, miss_count}, 32'h0);
    bus.mem_read = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.pmem_rdata = {8{16'hDEAD}};
    bus.pmem_resp = 1'b1;
    @(posedge clk); #1;
    bus.pmem_resp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stray_pmem_read", {31'h0, bus.pmem_read}, 32'h0);

    // Line was dropped by reset, so this misses again.
    do_miss(16'h8002, 2'b01, {8{16'h6789}}, 16'h0089, 1'b0, 1'b0, 16'h0);

    repeat (2) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
